// File: rtl/sdp_ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM with built-in clear.
package sdp_ram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/sdp_ram_clear_fsm.sv
// Clear sequencer: owns the state, the clear address counter and the choice
// between clear writes and user writes on the single internal write port.
module sdp_ram_clear_fsm
  import sdp_ram_pkg::*;
#(
  parameter int                  SIZE_ADDR      = 8,
  parameter int                  SIZE_DATA      = 32,
  parameter int                  NUM_BYTES      = SIZE_DATA / 8,
  parameter logic [SIZE_DATA-1:0] INIT_VALUE    = '0,
  parameter bit                  CLEAR_ON_RESET = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_init_start,
  input  logic                 i_wr_en,
  input  logic [SIZE_ADDR-1:0] i_wr_addr,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  input  logic [NUM_BYTES-1:0] i_wr_be,
  output logic                 o_state,
  output logic                 o_init_busy,
  output logic                 o_mem_we,
  output logic [SIZE_ADDR-1:0] o_mem_addr,
  output logic [SIZE_DATA-1:0] o_mem_data,
  output logic [NUM_BYTES-1:0] o_mem_be
);

  state_t               r_state;
  state_t               w_next_state;
  logic [SIZE_ADDR-1:0] r_clr_cnt;
  logic [SIZE_ADDR-1:0] w_next_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      if (CLEAR_ON_RESET) r_state <= S_CLEAR;
      else                r_state <= S_READY;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_cnt <= w_next_cnt;
    end
  end

  // The counter sits at zero in S_READY, so entering S_CLEAR always starts at word 0.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_next_cnt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == {SIZE_ADDR{1'b1}}) w_next_state = S_READY;
      end
      S_READY: begin
        w_next_cnt = '0;
        if (i_init_start) w_next_state = S_CLEAR;
      end
      default: begin
        w_next_state = S_READY;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    o_state     = r_state;
    o_init_busy = (r_state == S_CLEAR);
    if (r_state == S_CLEAR) begin
      o_mem_we   = 1'b1;
      o_mem_addr = r_clr_cnt;
      o_mem_data = INIT_VALUE;
      o_mem_be   = {NUM_BYTES{1'b1}};
    end else begin
      o_mem_we   = i_wr_en;
      o_mem_addr = i_wr_addr;
      o_mem_data = i_wr_data;
      o_mem_be   = i_wr_be;
    end
  end

endmodule

// File: rtl/sdp_ram_init.sv
// Simple-dual-port RAM with byte-enabled writes, 1- or 2-cycle reads,
// selectable read-during-write behaviour and a built-in clear sequencer.
module sdp_ram_init
  import sdp_ram_pkg::*;
#(
  parameter int                   SIZE_ADDR      = 8,
  parameter int                   SIZE_DATA      = 32,
  parameter int                   RD_LATENCY     = 1,
  parameter int                   RDW_MODE       = 0,
  parameter logic [SIZE_DATA-1:0] INIT_VALUE     = '0,
  parameter bit                   CLEAR_ON_RESET = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_init_start,
  output logic                     o_init_busy,
  input  logic                     i_wr_en,
  input  logic [SIZE_ADDR-1:0]     i_wr_addr,
  input  logic [SIZE_DATA-1:0]     i_wr_data,
  input  logic [SIZE_DATA/8-1:0]   i_wr_be,
  input  logic                     i_rd_en,
  input  logic [SIZE_ADDR-1:0]     i_rd_addr,
  output logic [SIZE_DATA-1:0]     o_rd_data,
  output logic                     o_rd_valid
);

  localparam int NUM_BYTES = SIZE_DATA / 8;
  localparam int DEPTH     = 1 << SIZE_ADDR;

  if (SIZE_DATA % 8 != 0) begin : g_bad_width
    $error("sdp_ram_init: SIZE_DATA must be a multiple of 8");
  end
  if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_latency
    $error("sdp_ram_init: RD_LATENCY must be 1 or 2");
  end

  logic [SIZE_DATA-1:0] r_mem [DEPTH];

  logic                 w_state;
  logic                 w_mem_we;
  logic [SIZE_ADDR-1:0] w_mem_addr;
  logic [SIZE_DATA-1:0] w_mem_data;
  logic [NUM_BYTES-1:0] w_mem_be;

  sdp_ram_clear_fsm #(
    .SIZE_ADDR      (SIZE_ADDR),
    .SIZE_DATA      (SIZE_DATA),
    .NUM_BYTES      (NUM_BYTES),
    .INIT_VALUE     (INIT_VALUE),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_init_start (i_init_start),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_wr_be      (i_wr_be),
    .o_state      (w_state),
    .o_init_busy  (o_init_busy),
    .o_mem_we     (w_mem_we),
    .o_mem_addr   (w_mem_addr),
    .o_mem_data   (w_mem_data),
    .o_mem_be     (w_mem_be)
  );

  // The array has no reset: its contents only change through the write port.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (w_mem_be[k]) r_mem[w_mem_addr][8*k +: 8] <= w_mem_data[8*k +: 8];
      end
    end
  end

  logic                 w_ready;
  logic                 w_rd_accept;
  logic                 w_wr_hit;
  logic [SIZE_DATA-1:0] w_rd_old;
  logic [SIZE_DATA-1:0] w_rd_merged;
  logic [SIZE_DATA-1:0] w_rd_word;

  assign w_ready     = (w_state == logic'(S_READY));
  assign w_rd_accept = i_rd_en && w_ready;
  assign w_wr_hit    = i_wr_en && w_ready && (i_wr_addr == i_rd_addr);
  assign w_rd_old    = r_mem[i_rd_addr];

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_merge
    assign w_rd_merged[8*k +: 8] = i_wr_be[k] ? i_wr_data[8*k +: 8] : w_rd_old[8*k +: 8];
  end

  // Reading the array before the edge gives READ_FIRST; WRITE_FIRST bypasses the merged word.
  assign w_rd_word = (RDW_MODE == RDW_WRITE_FIRST && w_wr_hit) ? w_rd_merged : w_rd_old;

  logic                 r_rd_valid1;
  logic [SIZE_DATA-1:0] r_rd_data1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_valid1 <= 1'b0;
      r_rd_data1  <= '0;
    end else begin
      r_rd_valid1 <= w_rd_accept;
      if (w_rd_accept) r_rd_data1 <= w_rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                 r_rd_valid2;
    logic [SIZE_DATA-1:0] r_rd_data2;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_rd_valid2 <= 1'b0;
        r_rd_data2  <= '0;
      end else begin
        r_rd_valid2 <= r_rd_valid1;
        if (r_rd_valid1) r_rd_data2 <= r_rd_data1;
      end
    end

    assign o_rd_valid = r_rd_valid2;
    assign o_rd_data  = r_rd_data2;
  end else begin : g_lat1
    assign o_rd_valid = r_rd_valid1;
    assign o_rd_data  = r_rd_data1;
  end

endmodule

// File: tb/tb_sdp_ram_init.sv
// Self-checking bench: three clearing RAMs (latency 1 read-first, latency 1
// write-first, latency 2 read-first) plus one no-clear-on-reset RAM, shared stimulus.
module tb_sdp_ram_init;

  localparam int          AW    = 4;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INIT  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_start = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          busy_rf1, busy_wf1, busy_rf2, busy_nc;
  logic [DW-1:0] data_rf1, data_wf1, data_rf2, data_nc;
  logic          valid_rf1, valid_wf1, valid_rf2, valid_nc;

  always #5 clk = ~clk;

  sdp_ram_init #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .RD_LATENCY(1), .RDW_MODE(0),
                 .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)) dut_rf1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_start(init_start), .o_init_busy(busy_rf1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(data_rf1), .o_rd_valid(valid_rf1));

  sdp_ram_init #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .RD_LATENCY(1), .RDW_MODE(1),
                 .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)) dut_wf1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_start(init_start), .o_init_busy(busy_wf1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(data_wf1), .o_rd_valid(valid_wf1));

  sdp_ram_init #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .RD_LATENCY(2), .RDW_MODE(0),
                 .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)) dut_rf2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_start(init_start), .o_init_busy(busy_rf2),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(data_rf2), .o_rd_valid(valid_rf2));

  sdp_ram_init #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .RD_LATENCY(1), .RDW_MODE(0),
                 .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_start(init_start), .o_init_busy(busy_nc),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(data_nc), .o_rd_valid(valid_nc));

  // Reference model: word array, clear progress, and reads due at a given cycle.
  typedef struct {
    int          inst;
    int          due;
    logic [31:0] d;
  } rd_item_t;

  rd_item_t    exp_q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_cnt;
  int          cyc;
  logic [31:0] last_d [3];
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] act_data(int i);
    case (i)
      0:       return data_rf1;
      1:       return data_wf1;
      default: return data_rf2;
    endcase
  endfunction

  function automatic logic act_valid(int i);
    case (i)
      0:       return valid_rf1;
      1:       return valid_wf1;
      default: return valid_rf2;
    endcase
  endfunction

  function automatic logic act_busy(int i);
    case (i)
      0:       return busy_rf1;
      1:       return busy_wf1;
      default: return busy_rf2;
    endcase
  endfunction

  // One clock: advance the model with the inputs the DUTs sampled, then score outputs.
  task automatic tick();
    logic [31:0] old_w;
    logic [31:0] new_w;
    logic        exp_v;
    logic [31:0] exp_d;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) last_d[i] = '0;
    end else if (m_busy) begin
      m_mem[m_cnt] = INIT;
      if (m_cnt == DEPTH - 1) m_busy = 1'b0;
      else                    m_cnt++;
    end else begin
      if (rd_en) begin
        old_w = m_mem[rd_addr];
        new_w = (wr_en && wr_addr == rd_addr) ? merge(old_w, wr_data, wr_be) : old_w;
        exp_q.push_back('{inst: 0, due: cyc,     d: old_w});
        exp_q.push_back('{inst: 1, due: cyc,     d: new_w});
        exp_q.push_back('{inst: 2, due: cyc + 1, d: old_w});
      end
      if (wr_en) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
      if (init_start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_v = 1'b0;
      exp_d = last_d[i];
      foreach (exp_q[j]) begin
        if (exp_q[j].inst == i && exp_q[j].due == cyc) begin
          exp_v = 1'b1;
          exp_d = exp_q[j].d;
        end
      end
      n_checks++;
      if (act_valid(i) !== exp_v) begin
        n_fail++;
        $display("FAIL rd_valid inst%0d cyc%0d: got %b want %b", i, cyc, act_valid(i), exp_v);
      end
      n_checks++;
      if (act_data(i) !== exp_d) begin
        n_fail++;
        $display("FAIL rd_data inst%0d cyc%0d: got %h want %h", i, cyc, act_data(i), exp_d);
      end
      n_checks++;
      if (act_busy(i) !== m_busy) begin
        n_fail++;
        $display("FAIL init_busy inst%0d cyc%0d: got %b want %b", i, cyc, act_busy(i), m_busy);
      end
      last_d[i] = exp_d;
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].due <= cyc) exp_q.delete(j);
  endtask

  task automatic idle_inputs();
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    init_start = 1'b0;
    wr_be      = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    n_checks++;
    if (busy_nc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_noclear: got %b want 0", busy_nc);
    end
    n_checks++;
    if (valid_nc !== 1'b0 || data_nc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rd_noclear: got v=%b d=%h want v=0 d=0", valid_nc, data_nc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear_after_reset();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_rf1 && n < 100);
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL reset_clear_len: got %0d want %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      tick();
      n_checks++;
      if (valid_rf1 !== 1'b1 || data_rf1 !== INIT) begin
        n_fail++;
        $display("FAIL cleared_word addr%0d: got v=%b d=%h want v=1 d=%h", a, valid_rf1, data_rf1, INIT);
      end
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_byte_enable();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1122_3344; wr_be = 4'b0101;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (data_rf1 !== 32'hDE22_BE44) begin
      n_fail++;
      $display("FAIL byte_enable: got %h want DE22BE44", data_rf1);
    end
    repeat (2) tick();
  endtask

  task automatic test_rdw();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0; wr_be = 4'hF;
    tick();
    wr_data = 32'hAAAA_AAAA;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    n_checks++;
    if (data_rf1 !== 32'h0) begin
      n_fail++;
      $display("FAIL rdw_read_first: got %h want 00000000", data_rf1);
    end
    n_checks++;
    if (data_wf1 !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL rdw_write_first: got %h want AAAAAAAA", data_wf1);
    end
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (data_rf1 !== 32'hAAAA_AAAA || data_wf1 !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL rdw_after: got rf=%h wf=%h want AAAAAAAA", data_rf1, data_wf1);
    end
    repeat (2) tick();
  endtask

  task automatic test_lat2_stream();
    logic [31:0] want;
    for (int a = 0; a < 3; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h100 + 32'(a); wr_be = 4'hF;
      tick();
    end
    idle_inputs();
    for (int t = 0; t < 5; t++) begin
      rd_en   = (t < 3);
      rd_addr = AW'(t);
      tick();
      want = 32'h100 + 32'(t - 1);
      n_checks++;
      if (valid_rf2 !== (t >= 1 && t <= 3)) begin
        n_fail++;
        $display("FAIL lat2_valid t%0d: got %b want %b", t, valid_rf2, (t >= 1 && t <= 3));
      end
      if (t >= 1 && t <= 3) begin
        n_checks++;
        if (data_rf2 !== want) begin
          n_fail++;
          $display("FAIL lat2_data t%0d: got %h want %h", t, data_rf2, want);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_clear();
    int n;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n_checks++;
    if (busy_rf1 !== 1'b1) begin
      n_fail++;
      $display("FAIL init_busy_rise: got %b want 1", busy_rf1);
    end
    n = 0;
    do begin
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = $urandom; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd7;
      init_start = (n == 5);
      tick();
      n++;
      n_checks++;
      if (valid_rf1 !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_read_ignored n%0d: got %b want 0", n, valid_rf1);
      end
    end while (busy_rf1 && n < 100);
    idle_inputs();
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL clear_len_with_restart_req: got %0d want %0d", n, DEPTH);
    end
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (data_rf1 !== INIT) begin
      n_fail++;
      $display("FAIL busy_write_ignored: got %h want %h", data_rf1, INIT);
    end
    tick();
    // Pending latency-2 read is in flight when reset hits.
    rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (valid_rf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_valid: got %b want 0", valid_rf2);
    end
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_rf1 && n < 100);
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL clear_len_after_mid_reset: got %0d want %0d", n, DEPTH);
    end
  endtask

  task automatic test_init_ready();
    int n;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h5; wr_be = 4'hF;
    tick();
    wr_addr = 4'd10; wr_data = 32'h77; init_start = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (busy_rf1 !== 1'b1 || busy_nc !== 1'b1) begin
      n_fail++;
      $display("FAIL init_req_busy: got rf=%b nc=%b want 1", busy_rf1, busy_nc);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_rf1 && n < 100);
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL init_req_len: got %0d want %0d", n, DEPTH);
    end
    for (int a = 9; a <= 10; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      n_checks++;
      if (data_rf1 !== INIT) begin
        n_fail++;
        $display("FAIL init_req_overwrite addr%0d: got %h want %h", a, data_rf1, INIT);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      rd_en   = ($urandom_range(0, 2) != 0);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_en   = ($urandom_range(0, 1) != 0);
      wr_addr = ($urandom_range(0, 2) == 0) ? rd_addr : AW'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_busy   = 1'b1;
    m_cnt    = 0;
    for (int i = 0; i < 3; i++) last_d[i] = '0;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 'x;
    test_reset();
    test_clear_after_reset();
    test_byte_enable();
    test_rdw();
    test_lat2_stream();
    test_mid_clear();
    test_init_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
